// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day path: BCD field widths, load FSM
// state encoding, legal-time limits and BCD arithmetic helpers.
package clock_pkg;

    localparam int HH_W = 6;
    localparam int MM_W = 7;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [1:0] MAX_HH_T      = 2'd2;
    localparam logic [3:0] MAX_HH_U_AT_2 = 4'd3;
    localparam logic [2:0] MAX_MM_T      = 3'd5;

    // Next BCD minute; 59 wraps to 00.
    function automatic logic [MM_W-1:0] inc_mm(input logic [MM_W-1:0] m);
        if (m[3:0] == 4'd9) begin
            if (m[6:4] == MAX_MM_T) inc_mm = '0;
            else                    inc_mm = {m[6:4] + 3'd1, 4'd0};
        end else begin
            inc_mm = {m[6:4], m[3:0] + 4'd1};
        end
    endfunction

    // Next BCD hour; 23 wraps to 00.
    function automatic logic [HH_W-1:0] inc_hh(input logic [HH_W-1:0] h);
        if (h == {MAX_HH_T, MAX_HH_U_AT_2})
            inc_hh = '0;
        else if (h[3:0] == 4'd9)
            inc_hh = {h[5:4] + 2'd1, 4'd0};
        else
            inc_hh = {h[5:4], h[3:0] + 4'd1};
    endfunction

    // True when the BCD pair is a legal 24-hour time of day.
    function automatic logic load_ok(input logic [HH_W-1:0] h, input logic [MM_W-1:0] m);
        load_ok = (h[5:4] <= MAX_HH_T) && (h[3:0] <= 4'd9) &&
                  ((h[5:4] < MAX_HH_T) || (h[3:0] <= MAX_HH_U_AT_2)) &&
                  (m[6:4] <= MAX_MM_T) && (m[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// Turns a toggle-encoded tick line into a one-cycle event: any transition of
// the (optionally synchronized) line raises ev for exactly one clock.
module toggle_edge_detect #(
    parameter bit SYNC_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tgl,
    output logic ev
);

    logic tgl_s;
    logic tgl_prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic sync_1;
            logic sync_2;

            // Two-flop synchronizer for a tick source on a foreign clock.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_1 <= 1'b0;
                    sync_2 <= 1'b0;
                end else begin
                    // NOTE: non-blocking so sync_2 takes the pre-edge sync_1; blocking would collapse the chain to one flop.
                    sync_1 <= tgl;
                    sync_2 <= sync_1;
                end
            end

            assign tgl_s = sync_2;
        end else begin : g_direct
            assign tgl_s = tgl;
        end
    endgenerate

    // Edge history: remember last cycle's level so any change shows up as ev.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tgl_prev <= 1'b0;
        else        tgl_prev <= tgl_s;
    end

    assign ev = tgl_s ^ tgl_prev;

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time of day with blinking colon, driven by toggle-encoded
// half-second and minute ticks, plus a validated valid/ready time-set load.
module time_keeper
    import clock_pkg::*;
#(
    parameter bit SYNC_EN  = 1'b0,
    parameter int RESET_HH = 0,
    parameter int RESET_MM = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            half_tgl,
    input  logic            min_tgl,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [HH_W-1:0] load_hh,
    input  logic [MM_W-1:0] load_mm,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic            colon,
    output logic            minute_strobe,
    output logic            hour_strobe,
    output logic            load_err
);

    localparam logic [HH_W-1:0] RST_HH_BCD = HH_W'((RESET_HH / 10) * 16 + (RESET_HH % 10));
    localparam logic [MM_W-1:0] RST_MM_BCD = MM_W'((RESET_MM / 10) * 16 + (RESET_MM % 10));

    logic            ev_half;
    logic            ev_min;
    logic [1:0]      state;
    logic [HH_W-1:0] cap_hh;
    logic [MM_W-1:0] cap_mm;
    logic            cap_ok;
    logic            commit_load;
    logic            min_apply;

    toggle_edge_detect #(.SYNC_EN(SYNC_EN)) u_half_edge (
        .clk   (clk),
        .reset (reset),
        .tgl   (half_tgl),
        .ev    (ev_half)
    );

    toggle_edge_detect #(.SYNC_EN(SYNC_EN)) u_min_edge (
        .clk   (clk),
        .reset (reset),
        .tgl   (min_tgl),
        .ev    (ev_min)
    );

    assign load_ready  = (state == IDLE);
    assign commit_load = (state == COMMIT) && cap_ok;
    // A valid load landing in COMMIT overrides a coincident minute tick.
    assign min_apply   = ev_min && !commit_load;

    // Load FSM: capture in IDLE, validate in CHECK, apply or reject in COMMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cap_hh <= '0;
            cap_mm <= '0;
            cap_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        cap_hh <= load_hh;
                        cap_mm <= load_mm;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    cap_ok <= load_ok(cap_hh, cap_mm);
                    state  <= COMMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Colon blinks on every half-second event regardless of load activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       colon <= 1'b0;
        else if (ev_half) colon <= ~colon;
    end

    // Time-of-day registers with strobes; a committed load takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hh            <= RST_HH_BCD;
            mm            <= RST_MM_BCD;
            minute_strobe <= 1'b0;
            hour_strobe   <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            minute_strobe <= min_apply;
            hour_strobe   <= min_apply && (mm == {MAX_MM_T, 4'd9});
            load_err      <= (state == COMMIT) && !cap_ok;
            if (commit_load) begin
                hh <= cap_hh;
                mm <= cap_mm;
            end else if (min_apply) begin
                mm <= inc_mm(mm);
                if (mm == {MAX_MM_T, 4'd9}) hh <= inc_hh(hh);
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper (SYNC_EN=0, reset time 00:00).
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       half_tgl;
    logic       min_tgl;
    logic       load_valid;
    logic       load_ready;
    logic [5:0] load_hh;
    logic [6:0] load_mm;
    logic [5:0] hh;
    logic [6:0] mm;
    logic       colon;
    logic       minute_strobe;
    logic       hour_strobe;
    logic       load_err;

    int n_checks = 0;
    int n_fails  = 0;
    int min_cnt, hour_cnt, err_cnt, double_cnt;
    logic prev_ms, prev_hs, prev_le;
    logic exp_colon;

    time_keeper #(.SYNC_EN(1'b0), .RESET_HH(0), .RESET_MM(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .half_tgl      (half_tgl),
        .min_tgl       (min_tgl),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_hh       (load_hh),
        .load_mm       (load_mm),
        .hh            (hh),
        .mm            (mm),
        .colon         (colon),
        .minute_strobe (minute_strobe),
        .hour_strobe   (hour_strobe),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample #1 after the edge; tally pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        min_cnt  += int'(minute_strobe);
        hour_cnt += int'(hour_strobe);
        err_cnt  += int'(load_err);
        if ((minute_strobe && prev_ms) || (hour_strobe && prev_hs) || (load_err && prev_le))
            double_cnt++;
        prev_ms = minute_strobe;
        prev_hs = hour_strobe;
        prev_le = load_err;
    endtask

    task automatic clr_counts();
        min_cnt  = 0;
        hour_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 20) begin
            cycle();
            n++;
        end
        check("ready_wait", load_ready, 1'b1);
    endtask

    // Full load handshake; garbage held on the bus while not ready must be ignored.
    task automatic do_load(input logic [5:0] h, input logic [6:0] m, input logic exp_ok,
                           input logic [5:0] eh, input logic [6:0] em);
        wait_ready();
        load_hh    = h;
        load_mm    = m;
        load_valid = 1'b1;
        cycle();
        load_hh = 6'h3f;
        load_mm = 7'h7f;
        check("ready_in_check", load_ready, 1'b0);
        cycle();
        load_valid = 1'b0;
        check("ready_in_commit", load_ready, 1'b0);
        cycle();
        check("ready_after_commit", load_ready, 1'b1);
        check("load_err", load_err, !exp_ok);
        check("load_hh", hh, eh);
        check("load_mm", mm, em);
        cycle();
        check("load_err_clear", load_err, 1'b0);
    endtask

    initial begin
        reset = 1'b0; half_tgl = 1'b0; min_tgl = 1'b0; load_valid = 1'b0;
        load_hh = '0; load_mm = '0;
        min_cnt = 0; hour_cnt = 0; err_cnt = 0; double_cnt = 0;
        prev_ms = 1'b0; prev_hs = 1'b0; prev_le = 1'b0;
        #1;
        check("rst_ready", load_ready, 1'b1);
        check("rst_hh", hh, 6'h00);
        check("rst_mm", mm, 7'h00);
        check("rst_colon", colon, 1'b0);
        repeat (3) cycle();
        reset = 1'b1;
        clr_counts();
        repeat (100) cycle();
        check("idle_hh", hh, 6'h00);
        check("idle_mm", mm, 7'h00);
        check("idle_colon", colon, 1'b0);
        check("idle_ready", load_ready, 1'b1);
        check("idle_min_strobes", min_cnt, 0);
        check("idle_hour_strobes", hour_cnt, 0);
        check("idle_errs", err_cnt, 0);

        // Colon: each half_tgl transition flips colon exactly one clock later.
        exp_colon = 1'b0;
        for (int i = 0; i < 4; i++) begin
            half_tgl = ~half_tgl;
            check("colon_before_edge", colon, exp_colon);
            cycle();
            exp_colon = ~exp_colon;
            check("colon_after_edge", colon, exp_colon);
            repeat (2) cycle();
            check("colon_hold", colon, exp_colon);
        end

        // 23:58 -> 23:59 -> 00:00.
        clr_counts();
        do_load(6'h23, 7'h58, 1'b1, 6'h23, 7'h58);
        min_tgl = ~min_tgl;
        cycle();
        check("m1_hh", hh, 6'h23);
        check("m1_mm", mm, 7'h59);
        check("m1_minute_strobe", minute_strobe, 1'b1);
        check("m1_hour_strobe", hour_strobe, 1'b0);
        cycle();
        check("m1_strobe_clear", minute_strobe, 1'b0);
        min_tgl = ~min_tgl;
        cycle();
        check("wrap_hh", hh, 6'h00);
        check("wrap_mm", mm, 7'h00);
        check("wrap_hour_strobe", hour_strobe, 1'b1);
        cycle();
        check("wrap_hour_clear", hour_strobe, 1'b0);
        check("wrap_min_count", min_cnt, 2);
        check("wrap_hour_count", hour_cnt, 1);

        // 09:59 -> 10:00.
        do_load(6'h09, 7'h59, 1'b1, 6'h09, 7'h59);
        min_tgl = ~min_tgl;
        cycle();
        check("h9_hh", hh, 6'h10);
        check("h9_mm", mm, 7'h00);
        check("h9_hour_strobe", hour_strobe, 1'b1);

        // 00:09 -> 00:10.
        do_load(6'h00, 7'h09, 1'b1, 6'h00, 7'h09);
        min_tgl = ~min_tgl;
        cycle();
        check("m9_hh", hh, 6'h00);
        check("m9_mm", mm, 7'h10);
        check("m9_hour_strobe", hour_strobe, 1'b0);

        // Illegal loads are rejected with a one-cycle error; time unchanged.
        clr_counts();
        do_load(6'h24, 7'h00, 1'b0, 6'h00, 7'h10);
        do_load(6'h12, 7'h60, 1'b0, 6'h00, 7'h10);
        check("bad_err_count", err_cnt, 2);

        // Minute event in COMMIT with a good load: dropped.
        clr_counts();
        wait_ready();
        load_hh = 6'h12; load_mm = 7'h34; load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        cycle();
        check("ovc_in_commit", load_ready, 1'b0);
        min_tgl = ~min_tgl;
        cycle();
        check("ovc_hh", hh, 6'h12);
        check("ovc_mm", mm, 7'h34);
        check("ovc_minute_strobe", minute_strobe, 1'b0);
        repeat (3) cycle();
        check("ovc_min_count", min_cnt, 0);

        // Minute event in CHECK: applied, then overwritten by the load.
        clr_counts();
        wait_ready();
        load_hh = 6'h12; load_mm = 7'h34; load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        min_tgl = ~min_tgl;
        cycle();
        check("ovk_mid_mm", mm, 7'h35);
        check("ovk_minute_strobe", minute_strobe, 1'b1);
        cycle();
        check("ovk_hh", hh, 6'h12);
        check("ovk_mm", mm, 7'h34);
        check("ovk_min_count", min_cnt, 1);

        // Reset mid-load discards the captured value.
        wait_ready();
        load_hh = 6'h05; load_mm = 7'h05; load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        reset = 1'b0; half_tgl = 1'b0; min_tgl = 1'b0;
        #1;
        check("mid_rst_hh", hh, 6'h00);
        check("mid_rst_ready", load_ready, 1'b1);
        cycle();
        reset = 1'b1;
        repeat (5) cycle();
        check("post_rst_hh", hh, 6'h00);
        check("post_rst_mm", mm, 7'h00);
        check("post_rst_colon", colon, 1'b0);
        check("post_rst_ready", load_ready, 1'b1);

        check("no_double_pulse", double_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
